// File: rtl/tachyon_lcd_pkg.sv
// Shared constants for the LCD bus receiver: ctrl bit positions, HD44780 command
// opcodes/masks, strobe FSM encoding and transaction sizing.
package tachyon_lcd_pkg;

  localparam int unsigned RS_BIT = 0;
  localparam int unsigned RW_BIT = 1;
  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_DDRAM      = 8'h80;
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam int unsigned ENTRY_INC_BIT = 1;

  typedef enum logic {
    STB_IDLE,
    STB_HIGH
  } strobe_state_t;

  // Transaction layout is {rs, data, addr}
  function automatic int unsigned txn_width(input int unsigned addr_w);
    return 1 + DATA_W + addr_w;
  endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees the slot in the same cycle.
module lcd_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Head is forced to zero when empty so downstream sees clean outputs after reset
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receive side of an 8-bit HD44780-style bus: synchronises E/RS/RW/data, qualifies
// strobes, tracks the DDRAM cursor and queues decoded writes on a valid/ready stream.
module lcd_bus_receiver
  import tachyon_lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MIN_E_HIGH = 2,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        lcd_data,
  input  logic [1:0]        lcd_ctrl,
  input  logic              lcd_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_rs,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              overflow,
  output logic              glitch,
  output logic              read_seen,
  input  logic              clear_flags
);

  localparam int unsigned TXN_W = txn_width(ADDR_W);
  localparam int unsigned CNT_W = $clog2(MIN_E_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_E_HIGH);

  logic       e_s1, e_s2;
  logic [7:0] data_s1, data_s2, data_p;
  logic [1:0] ctrl_s1, ctrl_s2, ctrl_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_s1    <= 1'b0;
      e_s2    <= 1'b0;
      data_s1 <= '0;
      data_s2 <= '0;
      data_p  <= '0;
      ctrl_s1 <= '0;
      ctrl_s2 <= '0;
      ctrl_p  <= '0;
    end else begin
      e_s1    <= lcd_enable;
      e_s2    <= e_s1;
      data_s1 <= lcd_data;
      data_s2 <= data_s1;
      data_p  <= data_s2;
      ctrl_s1 <= lcd_ctrl;
      ctrl_s2 <= ctrl_s1;
      ctrl_p  <= ctrl_s2;
    end
  end

  strobe_state_t    state, state_next;
  logic [CNT_W-1:0] high_cnt;
  logic             strobe_ok;
  logic             strobe_short;

  always_ff @(posedge clk) begin
    if (rst) state <= STB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      STB_IDLE: if (e_s2)  state_next = STB_HIGH;
      STB_HIGH: if (!e_s2) state_next = STB_IDLE;
      default:             state_next = STB_IDLE;
    endcase
  end

  always_comb begin
    strobe_ok    = 1'b0;
    strobe_short = 1'b0;
    if (state == STB_HIGH && !e_s2) begin
      strobe_ok    = (high_cnt >= CNT_MIN);
      strobe_short = (high_cnt <  CNT_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt <= '0;
    end else if (state == STB_IDLE && e_s2) begin
      high_cnt <= CNT_W'(1);
    end else if (state == STB_HIGH && e_s2 && high_cnt < CNT_MIN) begin
      high_cnt <= high_cnt + 1'b1;
    end
  end

  // data_p/ctrl_p still hold the bus values from the last cycle E was seen high
  logic       pend, pend_rs, pend_rw;
  logic [7:0] pend_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_rs   <= 1'b0;
      pend_rw   <= 1'b0;
      pend_data <= '0;
    end else begin
      pend <= strobe_ok;
      if (strobe_ok) begin
        pend_rs   <= ctrl_p[RS_BIT];
        pend_rw   <= ctrl_p[RW_BIT];
        pend_data <= data_p;
      end
    end
  end

  logic write_req, read_done;
  logic fifo_full, fifo_empty, pop;
  logic [TXN_W-1:0] head;

  assign write_req = pend && !pend_rw;
  assign read_done = pend && pend_rw;
  assign pop       = out_valid && out_ready;

  lcd_rx_fifo #(
    .WIDTH (TXN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (write_req),
    .push_data ({pend_rs, pend_data, cursor_addr}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid                   = !fifo_empty;
  assign {out_rs, out_data, out_addr} = head;

  logic              dir_inc, dir_inc_next;
  logic [ADDR_W-1:0] cursor_next;

  always_comb begin
    cursor_next  = cursor_addr;
    dir_inc_next = dir_inc;
    if (write_req) begin
      if (pend_rs) begin
        cursor_next = dir_inc ? cursor_addr + 1'b1 : cursor_addr - 1'b1;
      end else if ((pend_data & CMD_DDRAM_MASK) == CMD_DDRAM) begin
        cursor_next = ADDR_W'(pend_data[6:0]);
      end else if ((pend_data & CMD_ENTRY_MASK) == CMD_ENTRY) begin
        dir_inc_next = pend_data[ENTRY_INC_BIT];
      end else if ((pend_data & CMD_HOME_MASK) == CMD_HOME) begin
        cursor_next = '0;
      end else if (pend_data == CMD_CLEAR) begin
        cursor_next  = '0;
        dir_inc_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_addr <= '0;
      dir_inc     <= 1'b1;
      overflow    <= 1'b0;
      glitch      <= 1'b0;
      read_seen   <= 1'b0;
    end else begin
      cursor_addr <= cursor_next;
      dir_inc     <= dir_inc_next;
      overflow    <= (write_req && fifo_full && !pop) || (overflow  && !clear_flags);
      glitch      <= strobe_short                     || (glitch    && !clear_flags);
      read_seen   <= read_done                        || (read_seen && !clear_flags);
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: table of bus strobes with expected cursor/flags,
// a scoreboard queue for emitted transactions, and hand-written corner sequences.
module tb_lcd_bus_receiver;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic       out_valid;
  logic       out_ready;
  logic       out_rs;
  logic [7:0] out_data;
  logic [6:0] out_addr;
  logic [6:0] cursor_addr;
  logic       overflow;
  logic       glitch;
  logic       read_seen;
  logic       clear_flags;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb [$];

  always #5 clk = ~clk;

  lcd_bus_receiver #(
    .FIFO_DEPTH (DEPTH),
    .MIN_E_HIGH (2),
    .ADDR_W     (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_data    (lcd_data),
    .lcd_ctrl    (lcd_ctrl),
    .lcd_enable  (lcd_enable),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs      (out_rs),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .cursor_addr (cursor_addr),
    .overflow    (overflow),
    .glitch      (glitch),
    .read_seen   (read_seen),
    .clear_flags (clear_flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted beat is compared against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("txn_unexpected", {out_rs, out_data, out_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("txn", {16'h0, out_rs, out_data, out_addr}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi,
                        input logic push, input logic [6:0] addr);
    cyc(1);
    lcd_ctrl = {rw, rs};
    lcd_data = d;
    cyc(1);
    lcd_enable = 1'b1;
    cyc(hi);
    lcd_enable = 1'b0;
    if (push) sb.push_back({rs, d, addr});
    cyc(8);
  endtask

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] data;
    int         hi;
    logic       push;
    logic [6:0] exp_addr;
    logic [6:0] exp_cursor;
    logic [1:0] exp_flags;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic rs, input logic rw, input logic [7:0] d, input int hi,
                     input logic push, input logic [6:0] a, input logic [6:0] c,
                     input logic [1:0] f);
    vec_t v;
    v.rs = rs; v.rw = rw; v.data = d; v.hi = hi; v.push = push;
    v.exp_addr = a; v.exp_cursor = c; v.exp_flags = f;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // rs rw data hi push addr cursor {read_seen,glitch}
    add(0, 0, 8'h85, 4, 1, 7'h00, 7'h05, 2'b00);
    add(1, 0, 8'h41, 4, 1, 7'h05, 7'h06, 2'b00);
    add(1, 0, 8'h42, 4, 1, 7'h06, 7'h07, 2'b00);
    add(0, 0, 8'h04, 4, 1, 7'h07, 7'h07, 2'b00);
    add(0, 0, 8'h80, 3, 1, 7'h07, 7'h00, 2'b00);
    add(1, 0, 8'h30, 3, 1, 7'h00, 7'h7F, 2'b00);
    add(0, 0, 8'h01, 3, 1, 7'h7F, 7'h00, 2'b00);
    add(1, 0, 8'h61, 3, 1, 7'h00, 7'h01, 2'b00);
    add(0, 0, 8'hFF, 3, 1, 7'h01, 7'h7F, 2'b00);
    add(1, 0, 8'h62, 3, 1, 7'h7F, 7'h00, 2'b00);
    add(1, 0, 8'h63, 2, 1, 7'h00, 7'h01, 2'b00);
    add(0, 0, 8'h03, 3, 1, 7'h01, 7'h00, 2'b00);
    add(0, 0, 8'h10, 3, 1, 7'h00, 7'h00, 2'b00);
    add(1, 0, 8'h64, 3, 1, 7'h00, 7'h01, 2'b00);
    add(0, 0, 8'h02, 3, 1, 7'h01, 7'h00, 2'b00);
    add(0, 1, 8'h00, 3, 0, 7'h00, 7'h00, 2'b10);
    add(1, 0, 8'h55, 1, 0, 7'h00, 7'h00, 2'b11);

    rst = 1'b1; lcd_data = '0; lcd_ctrl = '0; lcd_enable = 1'b0;
    out_ready = 1'b1; clear_flags = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_cursor", cursor_addr, 7'h00);
    chk("reset_flags", {overflow, glitch, read_seen}, 3'b000);
    chk("reset_data", {out_rs, out_data, out_addr}, 16'h0);

    foreach (vecs[i]) begin
      strobe(vecs[i].rs, vecs[i].rw, vecs[i].data, vecs[i].hi, vecs[i].push, vecs[i].exp_addr);
      chk($sformatf("cursor[%0d]", i), cursor_addr, vecs[i].exp_cursor);
      chk($sformatf("flags[%0d]", i), {read_seen, glitch}, vecs[i].exp_flags);
      chk($sformatf("drained[%0d]", i), {31'(sb.size()), out_valid}, 32'h0);
    end

    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    cyc(1);
    chk("clear_flags", {overflow, glitch, read_seen}, 3'b000);

    // Fall-to-valid latency: 2 sync + 1 detect + 1 push
    out_ready = 1'b0;
    lcd_ctrl = 2'b01; lcd_data = 8'h70;
    cyc(1);
    lcd_enable = 1'b1;
    cyc(3);
    lcd_enable = 1'b0;
    sb.push_back({1'b1, 8'h70, 7'h00});
    cyc(3);
    chk("latency_early", out_valid, 1'b0);
    cyc(1);
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_data", out_data, 8'h70);
    cyc(3);
    chk("hold_stable", {out_rs, out_data, out_addr}, {1'b1, 8'h70, 7'h00});
    out_ready = 1'b1;
    cyc(3);
    chk("latency_drain", sb.size(), 0);
    strobe(0, 0, 8'h01, 3, 1, 7'h01);
    chk("clear_cursor", cursor_addr, 7'h00);

    // Overflow: DEPTH+1 writes with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      strobe(1, 0, 8'hA0 + 8'(i), 3, (i < DEPTH), 7'(i));
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_cursor", cursor_addr, 7'(DEPTH + 1));
    chk("ovf_head", {out_valid, out_data, out_addr}, {1'b1, 8'hA0, 7'h00});
    out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0; n++) cyc(1);
    chk("ovf_drain", sb.size(), 0);
    cyc(2);
    chk("ovf_empty", out_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset with entries queued and E held high
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe(1, 0, 8'hC0 + 8'(i), 3, 1'b0, 7'h00);
    chk("pre_reset_valid", out_valid, 1'b1);
    lcd_ctrl = 2'b01; lcd_data = 8'h99;
    lcd_enable = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(3);
    lcd_enable = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cursor", cursor_addr, 7'h00);
    chk("rst_overflow", overflow, 1'b0);
    cyc(6);
    chk("rst_no_glitch", {glitch, out_valid}, 2'b00);
    out_ready = 1'b1;
    strobe(1, 0, 8'h5A, 3, 1, 7'h00);
    chk("post_rst_cursor", cursor_addr, 7'h01);
    chk("post_rst_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receive-side end of the 8-bit HD44780-style LCD bus driven by tachyon_rv (lcd_data, lcd_ctrl, lcd_enable).
- Synchronises the asynchronous bus, latches each transfer on the falling edge of the enable strobe, and classifies it as command or data.
- Tracks the controller's DDRAM cursor address and entry direction.
- Presents decoded write transactions on a valid/ready stream through a small FIFO, for on-FPGA bus capture, loopback checking and simulation scoreboarding.

Parameters:
- FIFO_DEPTH, 8, transaction FIFO entries; power of two, at least 2.
- MIN_E_HIGH, 2, minimum synchronised cycles lcd_enable must be high for a strobe to count as valid.
- ADDR_W, 7, DDRAM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- lcd_data  in  8  LCD data bus (asynchronous).
- lcd_ctrl  in  2  bit0 = RS (1 = data, 0 = command); bit1 = RW (1 = read); asynchronous.
- lcd_enable  in  1  E strobe (asynchronous).
- out_valid  out  1  transaction available.
- out_ready  in  1  consumer accepts the transaction.
- out_rs  out  1  RS of the head transaction.
- out_data  out  8  byte of the head transaction.
- out_addr  out  ADDR_W  cursor address before this transaction was applied.
- cursor_addr  out  ADDR_W  current tracked cursor address.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- glitch  out  1  sticky: a strobe shorter than MIN_E_HIGH was seen.
- read_seen  out  1  sticky: an RW=1 strobe completed.
- clear_flags  in  1  clears overflow, glitch and read_seen.

Behaviour:
- Reset: synchronous; rst is sampled on the clk rising edge.
  - All outputs go to 0.
  - FIFO is emptied, cursor_addr = 0, direction = increment.
  - Synchroniser flops are cleared, so E is treated as low.
- Synchroniser:
  - Two flops on every bus input.
  - A third register holds the synchronised data and ctrl from the previous cycle.
- Strobe state machine:
  - IDLE: on synchronised E = 1, go to HIGH and reset the high-counter to 1.
  - HIGH: count up, saturating at MIN_E_HIGH. On synchronised E = 0, go to IDLE:
    - If count ≥ MIN_E_HIGH: the strobe is valid. Latch data and ctrl from the previous-cycle register (the values present while E was high).
    - Otherwise: set glitch and discard the strobe.
- Valid strobe, RW = 1: set read_seen. No push and no cursor change.
- Valid strobe, RW = 0: push {rs, data, cursor_addr} in the cycle after the fall is detected, then update the cursor in the same cycle:
  - RS = 1 (data): cursor += 1 if increment, −1 if decrement. Wraps modulo 2^ADDR_W (0x7F+1 → 0x00; 0x00−1 → 0x7F).
  - 0x01 clear: cursor = 0, direction = increment.
  - 0x02 or 0x03 home: cursor = 0.
  - 0b000001xx entry mode: direction = data[1].
  - 1xxxxxxx set DDRAM address: cursor = data[6:0].
  - Any other command: pushed, cursor unchanged.
- FIFO full at push time: the transaction is dropped and overflow is set. The cursor still updates, because the LCD accepted the write.
- Simultaneous pop and push when full: the push succeeds; the pop frees the slot in the same cycle.
- out_valid follows FIFO not-empty. The pop happens when out_valid and out_ready are both high. out_rs, out_data and out_addr are stable while out_valid is high and not accepted.
- Latency: from E falling at the pin to out_valid is 4 clk cycles: 2 synchroniser cycles, 1 detect cycle, 1 push cycle.
- Sticky flags: set has priority over clear_flags in the same cycle.
- Minimum strobe spacing: back-to-back valid strobes need at least 2 cycles of synchronised E low between them.
- Reset while E is high: the in-flight strobe is abandoned, with no push and no glitch.

Decomposition:
- Shared package tachyon_lcd_pkg holds:
  - RS and RW bit indices.
  - Command opcodes and masks: CLEAR, HOME, ENTRY_MODE, SET_DDRAM.
  - Strobe state encoding (IDLE, HIGH).
  - Packed transaction struct or width constant: 1 + 8 + ADDR_W.
- One sub-module, lcd_rx_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, and first-word-fall-through output.

Test Plan:
- Reset, then write command 0x80|0x05 followed by data 0x41 ('A') and 0x42, each strobe held 4 cycles → three transactions: {0, 0x85, 0x00}, {1, 0x41, 0x05}, {1, 0x42, 0x06}; cursor_addr = 0x07.
- Command 0x04 (decrement), set address 0x00, then data 0x30 → transaction out_addr = 0x00; cursor_addr = 0x7F (wrap). Then command 0x01 → cursor_addr = 0x00 and direction is increment again.
- E pulse of 1 synchronised cycle with data 0x55 → no transaction; glitch = 1. Assert clear_flags → glitch = 0.
- RW = 1 strobe → read_seen = 1; out_valid stays 0; cursor unchanged.
- Hold out_ready = 0 and send FIFO_DEPTH + 1 data writes → 8 entries held, overflow = 1, cursor advanced by 9. Then drain with out_ready = 1 → entries pop in order with addresses 0..7.
- Assert rst during a held E with the FIFO holding 3 entries → out_valid = 0 and cursor_addr = 0; the following clean strobe is received normally.
